// File: rtl/spi_flash_pkg.sv
// Shared constants and state encoding for the SPI flash responder.
package spi_flash_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  localparam logic [BYTE_W-1:0] OP_READ  = 8'h01;
  localparam logic [BYTE_W-1:0] OP_WRITE = 8'h02;
  localparam logic [BYTE_W-1:0] OP_RDSR  = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_RDATA  = 3'd2,
    ST_WDATA  = 3'd3,
    ST_IGNORE = 3'd4,
    ST_STATUS = 3'd5
  } spi_state_e;
endpackage

// File: rtl/spi_resp_mem.sv
// Word array behind the responder: synchronous write, asynchronous read, no reset.
module spi_resp_mem
  import spi_flash_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/spi_flash_responder.sv
// Byte-wide SPI NOR-flash responder serving 32-bit word reads/writes from internal RAM.
// Optional feature macro: SPI_RESP_STATUS_EN (opcode 0x05 read-status).
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              s_clk,
  input  logic              s_reset,
  input  logic              s_css,
  input  logic [BYTE_W-1:0] s_mosi,
  output logic [BYTE_W-1:0] s_miso,
  output logic              resp_busy,
  output logic              resp_err,
  output logic [2:0]        dbg_state,
  output logic [23:0]       dbg_addr
);
  // Link semantics: s_mosi carries a valid byte at every posedge with s_css=0;
  // there is no backpressure, and s_miso is valid the cycle after each such edge.
  spi_state_e        state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic [23:0]       addr, addr_nxt;
  logic [AW-1:0]     idx, idx_nxt;
  logic [WORD_W-1:0] word, word_nxt;
  logic [23:0]       wbuf, wbuf_nxt;
  logic [BYTE_W-1:0] miso_nxt;
  logic              err_nxt;
  logic              is_read, is_read_nxt;
  logic [23:0]       full_addr;
  logic [AW-1:0]     rd_idx;
  logic              mem_we;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  // The low address byte is used the same edge it arrives, so the first read
  // word is fetched combinationally from the incoming byte.
  assign full_addr = {addr[23:8], s_mosi};
  assign rd_idx    = (state == ST_ADDR) ? full_addr[AW-1:0] : idx;
  assign mem_wdata = {wbuf, s_mosi};

  spi_resp_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (s_clk),
    .we    (mem_we),
    .waddr (idx),
    .wdata (mem_wdata),
    .raddr (rd_idx),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    addr_nxt    = addr;
    idx_nxt     = idx;
    word_nxt    = word;
    wbuf_nxt    = wbuf;
    miso_nxt    = '0;
    err_nxt     = resp_err;
    is_read_nxt = is_read;
    mem_we      = 1'b0;
    if (s_css) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_nxt = 2'd1;
          if (s_mosi == OP_READ || s_mosi == OP_WRITE) begin
            state_nxt   = ST_ADDR;
            is_read_nxt = (s_mosi == OP_READ);
`ifdef SPI_RESP_STATUS_EN
          end else if (s_mosi == OP_RDSR) begin
            state_nxt = ST_STATUS;
`endif
          end else begin
            state_nxt = ST_IGNORE;
            err_nxt   = 1'b1;
          end
        end
        ST_ADDR: begin
          case (cnt)
            2'd1: begin addr_nxt[23:16] = s_mosi; cnt_nxt = 2'd2; end
            2'd2: begin addr_nxt[15:8]  = s_mosi; cnt_nxt = 2'd3; end
            default: begin
              addr_nxt = full_addr;
              idx_nxt  = full_addr[AW-1:0];
              cnt_nxt  = 2'd0;
              if (is_read) begin
                word_nxt  = mem_rdata;
                miso_nxt  = mem_rdata[31:24];
                cnt_nxt   = 2'd1;
                state_nxt = ST_RDATA;
              end else begin
                state_nxt = ST_WDATA;
              end
            end
          endcase
        end
        ST_RDATA: begin
          case (cnt)
            2'd0: begin
              word_nxt = mem_rdata;
              miso_nxt = mem_rdata[31:24];
              cnt_nxt  = 2'd1;
            end
            2'd1: begin miso_nxt = word[23:16]; cnt_nxt = 2'd2; end
            2'd2: begin miso_nxt = word[15:8];  cnt_nxt = 2'd3; end
            default: begin
              miso_nxt = word[7:0];
              idx_nxt  = idx + 1'b1;
              cnt_nxt  = 2'd0;
            end
          endcase
        end
        ST_WDATA: begin
          if (cnt == 2'd3) begin
            mem_we  = 1'b1;
            idx_nxt = idx + 1'b1;
            cnt_nxt = 2'd0;
          end else begin
            wbuf_nxt = {wbuf[15:0], s_mosi};
            cnt_nxt  = cnt + 2'd1;
          end
        end
`ifdef SPI_RESP_STATUS_EN
        ST_STATUS: begin
          miso_nxt = {6'b0, resp_err, mem_we};
          err_nxt  = 1'b0;
        end
`endif
        default: ;
      endcase
    end
    // Reset wins over a commit landing on the same edge.
    if (s_reset) mem_we = 1'b0;
  end

  always_ff @(posedge s_clk) begin
    if (s_reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      addr     <= '0;
      idx      <= '0;
      word     <= '0;
      wbuf     <= '0;
      s_miso   <= '0;
      resp_err <= 1'b0;
      is_read  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      addr     <= addr_nxt;
      idx      <= idx_nxt;
      word     <= word_nxt;
      wbuf     <= wbuf_nxt;
      s_miso   <= miso_nxt;
      resp_err <= err_nxt;
      is_read  <= is_read_nxt;
    end
  end

  assign resp_busy = (state != ST_IDLE);
  assign dbg_state = state;
  assign dbg_addr  = addr;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed self-checking bench for spi_flash_responder (status checks when SPI_RESP_STATUS_EN is set).
module tb_spi_flash_responder;
  logic       s_clk = 1'b0;
  logic       s_reset;
  logic       s_css;
  logic [7:0] s_mosi;
  logic [7:0] s_miso;
  logic       resp_busy;
  logic       resp_err;
  logic [2:0] dbg_state;
  logic [23:0] dbg_addr;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] r;

  spi_flash_responder #(.DEPTH(256), .AW(8)) dut (
    .s_clk     (s_clk),
    .s_reset   (s_reset),
    .s_css     (s_css),
    .s_mosi    (s_mosi),
    .s_miso    (s_miso),
    .resp_busy (resp_busy),
    .resp_err  (resp_err),
    .dbg_state (dbg_state),
    .dbg_addr  (dbg_addr)
  );

  // clock / reset
  always #5 s_clk = ~s_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic xfer(input logic [7:0] b, output logic [7:0] rb);
    @(negedge s_clk);
    s_css  = 1'b0;
    s_mosi = b;
    @(posedge s_clk);
    #1 rb = s_miso;
  endtask

  task automatic desel();
    @(negedge s_clk);
    s_css  = 1'b1;
    s_mosi = 8'h00;
    @(posedge s_clk);
    #1;
  endtask

  task automatic write_bytes(input logic [23:0] a, input logic [7:0] d[$]);
    logic [7:0] rb;
    xfer(8'h02, rb);
    xfer(a[23:16], rb);
    xfer(a[15:8], rb);
    xfer(a[7:0], rb);
    foreach (d[i]) xfer(d[i], rb);
    desel();
  endtask

  // scoreboard: each byte seen on s_miso is checked against exp_q in order
  task automatic read_check(input string tag, input logic [23:0] a, input int n);
    logic [7:0] rb;
    xfer(8'h01, rb);
    xfer(a[23:16], rb);
    xfer(a[15:8], rb);
    xfer(a[7:0], rb);
    for (int i = 0; i < n; i++) begin
      if (i > 0) xfer(8'h00, rb);
      if (exp_q.size() == 0) begin
        check_val({tag, "_qempty"}, 32'd1, 32'd0);
      end else begin
        check_val($sformatf("%s_b%0d", tag, i), {24'h0, rb}, {24'h0, exp_q.pop_front()});
      end
    end
    desel();
  endtask

  initial begin
    s_reset = 1'b1;
    s_css   = 1'b1;
    s_mosi  = 8'h00;
    repeat (3) @(posedge s_clk);
    #1;
    check_val("rst_miso", {24'h0, s_miso}, 32'h0);
    check_val("rst_busy", {31'h0, resp_busy}, 32'h0);
    check_val("rst_err", {31'h0, resp_err}, 32'h0);
    check_val("rst_state", {29'h0, dbg_state}, 32'h0);
    @(negedge s_clk);
    s_reset = 1'b0;

    // write DEADBEEF to word 4, watching busy/miso mid-transaction
    xfer(8'h02, r);
    check_val("wr_busy", {31'h0, resp_busy}, 32'h1);
    check_val("wr_miso_op", {24'h0, r}, 32'h0);
    xfer(8'h00, r);
    xfer(8'h00, r);
    xfer(8'h04, r);
    check_val("wr_miso_addr", {24'h0, r}, 32'h0);
    xfer(8'hDE, r);
    xfer(8'hAD, r);
    xfer(8'hBE, r);
    xfer(8'hEF, r);
    check_val("wr_miso_data", {24'h0, r}, 32'h0);
    desel();
    check_val("wr_idle", {31'h0, resp_busy}, 32'h0);

    exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    read_check("rd4", 24'h000004, 4);

    // burst write across the wrap: word 255 then word 0
    write_bytes(24'h0000FF, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    read_check("wrap", 24'h0000FF, 8);

    // unknown opcode
    xfer(8'h9F, r);
    check_val("unk_miso0", {24'h0, r}, 32'h0);
    xfer(8'h01, r);
    xfer(8'h00, r);
    check_val("unk_miso1", {24'h0, r}, 32'h0);
    xfer(8'h04, r);
    check_val("unk_miso2", {24'h0, r}, 32'h0);
    check_val("unk_err", {31'h0, resp_err}, 32'h1);
    desel();
    check_val("unk_err_sticky", {31'h0, resp_err}, 32'h1);

`ifdef SPI_RESP_STATUS_EN
    xfer(8'h05, r);
    xfer(8'h00, r);
    check_val("rdsr1", {24'h0, r}, 32'h02);
    xfer(8'h00, r);
    check_val("rdsr1_rep", {24'h0, r}, 32'h00);
    desel();
    check_val("rdsr_err_clr", {31'h0, resp_err}, 32'h0);
    xfer(8'h05, r);
    xfer(8'h00, r);
    check_val("rdsr2", {24'h0, r}, 32'h00);
    desel();
`endif

    exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    read_check("after_unk", 24'h000004, 4);

    // write abort after 2 data bytes
    write_bytes(24'h000004, '{8'h12, 8'h34});
    exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    read_check("abort", 24'h000004, 4);

    // set err again so the reset check below also covers resp_err
    xfer(8'h9F, r);
    desel();

    // reset on the 3rd data byte of a write
    xfer(8'h02, r);
    xfer(8'h00, r);
    xfer(8'h00, r);
    xfer(8'h04, r);
    xfer(8'hAA, r);
    xfer(8'hBB, r);
    @(negedge s_clk);
    s_mosi  = 8'hCC;
    s_reset = 1'b1;
    @(posedge s_clk);
    #1;
    check_val("mrst_miso", {24'h0, s_miso}, 32'h0);
    check_val("mrst_busy", {31'h0, resp_busy}, 32'h0);
    check_val("mrst_err", {31'h0, resp_err}, 32'h0);
    @(negedge s_clk);
    s_reset = 1'b0;
    s_css   = 1'b1;
    @(posedge s_clk);
    #1;
    exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    read_check("mrst_rd", 24'h000004, 4);

    // word 0 from the wrapped burst must be intact too
    exp_q = '{8'h55, 8'h66, 8'h77, 8'h88};
    read_check("w0", 24'h000000, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
